riscv_reg_file: RTL and testbench
=================================

Name: riscv_reg_file

Overview:
RV32I integer register file: 32 x 32-bit registers, two combinational read ports, one synchronous write port. It sits in the core datapath between decode (rs1/rs2 addresses) and writeback (rd address and data). Register x0 is hardwired to zero.

Parameters:
XLEN, 32, data width of each register and of each read/write data port.
NREGS, 32, number of architectural registers, index 0 hardwired zero.
AW, 5, address width; must equal clog2(NREGS).
WR_BYPASS, 1, when 1 a read of the register being written in the same cycle returns the write data.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
we  input  1  write enable.
ra1  input  AW  read port 1 address.
ra2  input  AW  read port 2 address.
wa  input  AW  write address.
wd  input  XLEN  write data.
rd1  output  XLEN  read port 1 data (combinational).
rd2  output  XLEN  read port 2 data (combinational).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Storage: registers x1..x(NREGS-1), XLEN bits each.
- x0 has no storage. Reads of address 0 always return 0.
- Reset: at a rising clk edge with rst=1, all registers x1..x31 become 0.
- While rst=1, rd1 and rd2 are forced to 0 combinationally, including before the first edge. This gives a zero read immediately on reset assertion.
- Reset has priority over a write in the same cycle; the write is dropped.
- Write: at a rising clk edge with rst=0, we=1 and wa!=0, reg[wa] <= wd.
- we=0: no register changes, whatever wa/wd are.
- wa=0 with we=1: no effect.
- Write latency: the new value is visible at rd1/rd2 immediately after the edge (0-cycle read-after-write across the edge).
- Read: rd1 = reg[ra1] and rd2 = reg[ra2], purely combinational with no clock.
- Both ports are independent. ra1 == ra2 is legal and both return the same value.
- Bypass (WR_BYPASS=1): if rst=0, we=1, wa!=0 and ra1==wa (resp. ra2==wa), rd1 (resp. rd2) = wd in the same cycle, before the edge.
- Bypass (WR_BYPASS=0): the stored value is returned until the edge.
- Read priority: rst forcing, then x0 zero, then bypass, then stored value.
- No X propagation after reset: every readable register is defined from the first reset edge onward.
- Values are stored bit-exact. Full-width patterns (0xFFFFFFFF, 0x00000000, 0x55555555, 0xAAAAAAAA) round-trip unchanged.

Decomposition:
- Shared package (riscv_pkg): XLEN, NREGS, AW constants; typedef reg_addr_t (logic [AW-1:0]); typedef xword_t (logic [XLEN-1:0]).
- No sub-module. Storage array plus two read muxes live in riscv_reg_file. A read-port function (address -> data with x0/bypass handling) is shared by both ports.

Test Plan:
- Hold rst=1 two cycles, read (x1,x31) and (x15,x16) -> all 0. Release rst, read (x0,x0) -> 0,0.
- we=1, wa=0, wd=0xDEADBEEF, clock -> read (x0,x1) = 0,0. Write x1=0x12345678, x31=0xABCDEF00, x15=0x55AA55AA -> read (x31,x1) = 0xABCDEF00,0x12345678; (x15,x31) = 0x55AA55AA,0xABCDEF00; (x2,x2) after x2=0x11111111 -> both 0x11111111.
- we=0, wa=10, wd=0xBADBAD00, clock -> x10 reads 0. Then we=1 with wd=0xC00D0000 -> x10 reads 0xC00D0000. Earlier x1/x2/x15/x31 values persist.
- Loop i=1..10 writing 0x10000000+i -> pairs (x1,x6), (x3,x8), (x5,x10) read 0x10000001/06, 03/08, 05/0A. x20=0xFFFFFFFF, x21=0, x22=0x55555555, x23=0xAAAAAAAA read back exactly.
- Write x25=0x99999999, assert rst -> rd1 (x25) = 0 immediately. After one edge, release -> x25 stays 0. Write x26=0x77777777 -> (x26,x25) = 0x77777777,0.
- WR_BYPASS=1: we=1, wa=7, wd=0xCAFEF00D, ra1=7 before the edge -> rd1 = 0xCAFEF00D. Same cycle with rst=1 -> rd1 = 0 and x7 remains 0 after the edge.

Source files
------------

// File: rtl/riscv_reg_file_pkg.sv
// Shared RV32I register-file constants and types.
// Used by the register-file interface, the register-file module and the bench.
package riscv_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_addr_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/riscv_reg_file_if.sv
// Decode/writeback side of the register file: write port plus two read ports.
// The master drives addresses and write data; the slave (register file) returns read data.
interface riscv_reg_file_if;
    import riscv_pkg::*;

    logic      we;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_addr_t wa;
    xword_t    wd;
    xword_t    rd1;
    xword_t    rd2;

    modport master (output we, ra1, ra2, wa, wd, input rd1, rd2);
    modport slave  (input we, ra1, ra2, wa, wd, output rd1, rd2);

endinterface

// File: rtl/riscv_reg_file.sv
// RV32I integer register file: x1..x31 storage, x0 reads as zero,
// two combinational read ports and one synchronous write port.
module riscv_reg_file
    import riscv_pkg::*;
#(
    parameter int unsigned WR_BYPASS = 1
)
(
    input  logic               clk,
    input  logic               rst,
    riscv_reg_file_if.slave    rf
);

    xword_t regs [1:NREGS-1];
    xword_t stored1;
    xword_t stored2;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.we && (rf.wa != '0)) begin
            regs[rf.wa] <= rf.wd;
        end
    end

    // x0 has no storage, so the array is only indexed for non-zero addresses.
    always_comb begin
        stored1 = '0;
        stored2 = '0;
        if (rf.ra1 != '0) stored1 = regs[rf.ra1];
        if (rf.ra2 != '0) stored2 = regs[rf.ra2];
    end

    // Priority: reset forcing, x0 zero, same-cycle write bypass, stored value.
    function automatic xword_t read_port(
        input reg_addr_t ra,
        input xword_t    stored,
        input logic      rst_i,
        input logic      we_i,
        input reg_addr_t wa_i,
        input xword_t    wd_i
    );
        if (rst_i)
            return '0;
        if (ra == '0)
            return '0;
        if ((WR_BYPASS != 0) && we_i && (wa_i == ra))
            return wd_i;
        return stored;
    endfunction

    assign rf.rd1 = read_port(rf.ra1, stored1, rst, rf.we, rf.wa, rf.wd);
    assign rf.rd2 = read_port(rf.ra2, stored2, rst, rf.we, rf.wa, rf.wd);

endmodule

// File: tb/tb_riscv_reg_file.sv
// Bench for riscv_reg_file: directed plan plus random traffic against an array model,
// with a bypass-enabled and a bypass-disabled instance driven in parallel.
module tb_riscv_reg_file;
    import riscv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    xword_t m [NREGS];

    always #5 clk = ~clk;

    riscv_reg_file_if bus ();
    riscv_reg_file_if bus_nb ();

    assign bus_nb.we  = bus.we;
    assign bus_nb.ra1 = bus.ra1;
    assign bus_nb.ra2 = bus.ra2;
    assign bus_nb.wa  = bus.wa;
    assign bus_nb.wd  = bus.wd;

    riscv_reg_file #(.WR_BYPASS(1)) dut    (.clk(clk), .rst(rst), .rf(bus.slave));
    riscv_reg_file #(.WR_BYPASS(0)) dut_nb (.clk(clk), .rst(rst), .rf(bus_nb.slave));

    // Architectural view of a read with the current inputs.
    function automatic xword_t mread(input reg_addr_t a, input bit bypass);
        if (rst) return '0;
        if (a == 0) return '0;
        if (bypass && bus.we && bus.wa == a) return bus.wd;
        return m[a];
    endfunction

    task automatic cmp(input string tag, input xword_t obs, input xword_t exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input reg_addr_t a, input xword_t d,
                         input reg_addr_t r1, input reg_addr_t r2);
        bus.we = w; bus.wa = a; bus.wd = d; bus.ra1 = r1; bus.ra2 = r2;
    endtask

    task automatic probe(input string tag);
        cmp({tag, ".rd1"},    bus.rd1,    mread(bus.ra1, 1'b1));
        cmp({tag, ".rd2"},    bus.rd2,    mread(bus.ra2, 1'b1));
        cmp({tag, ".nb.rd1"}, bus_nb.rd1, mread(bus.ra1, 1'b0));
        cmp({tag, ".nb.rd2"}, bus_nb.rd2, mread(bus.ra2, 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREGS; i++) m[i] = '0;
        end else if (bus.we && bus.wa != 0) begin
            m[bus.wa] = bus.wd;
        end
        #1;
    endtask

    task automatic rd(input string tag, input reg_addr_t r1, input reg_addr_t r2,
                      input xword_t e1, input xword_t e2);
        drive(1'b0, '0, '0, r1, r2);
        #1;
        cmp({tag, ".c1"}, bus.rd1, e1);
        cmp({tag, ".c2"}, bus.rd2, e2);
        probe(tag);
    endtask

    task automatic wr(input reg_addr_t a, input xword_t d);
        drive(1'b1, a, d, a, '0);
        #1;
        probe("wr");
        tick();
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) m[i] = '0;
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        rd("rst_pre", 5'd1, 5'd31, 32'h0, 32'h0);
        tick();
        tick();
        rd("rst_hold", 5'd15, 5'd16, 32'h0, 32'h0);
        rst = 1'b0;
        rd("x0", 5'd0, 5'd0, 32'h0, 32'h0);

        wr(5'd0, 32'hDEADBEEF);
        rd("wr_x0", 5'd0, 5'd1, 32'h0, 32'h0);
        wr(5'd1, 32'h12345678);
        wr(5'd31, 32'hABCDEF00);
        wr(5'd15, 32'h55AA55AA);
        rd("rd31_1", 5'd31, 5'd1, 32'hABCDEF00, 32'h12345678);
        rd("rd15_31", 5'd15, 5'd31, 32'h55AA55AA, 32'hABCDEF00);
        wr(5'd2, 32'h11111111);
        rd("same_addr", 5'd2, 5'd2, 32'h11111111, 32'h11111111);

        drive(1'b0, 5'd10, 32'hBADBAD00, 5'd10, 5'd10);
        #1;
        probe("we0_pre");
        tick();
        rd("we0", 5'd10, 5'd10, 32'h0, 32'h0);
        wr(5'd10, 32'hC00D0000);
        rd("x10", 5'd10, 5'd1, 32'hC00D0000, 32'h12345678);
        rd("persist", 5'd2, 5'd15, 32'h11111111, 32'h55AA55AA);
        rd("persist31", 5'd31, 5'd31, 32'hABCDEF00, 32'hABCDEF00);

        for (int i = 1; i <= 10; i++) wr(reg_addr_t'(i), 32'h10000000 + xword_t'(i));
        rd("loop1_6", 5'd1, 5'd6, 32'h10000001, 32'h10000006);
        rd("loop3_8", 5'd3, 5'd8, 32'h10000003, 32'h10000008);
        rd("loop5_10", 5'd5, 5'd10, 32'h10000005, 32'h1000000A);
        wr(5'd20, 32'hFFFFFFFF);
        wr(5'd21, 32'h00000000);
        wr(5'd22, 32'h55555555);
        wr(5'd23, 32'hAAAAAAAA);
        rd("pat20_21", 5'd20, 5'd21, 32'hFFFFFFFF, 32'h00000000);
        rd("pat22_23", 5'd22, 5'd23, 32'h55555555, 32'hAAAAAAAA);

        wr(5'd25, 32'h99999999);
        rd("x25", 5'd25, 5'd25, 32'h99999999, 32'h99999999);
        rst = 1'b1;
        #1;
        cmp("rst_imm", bus.rd1, 32'h0);
        tick();
        rst = 1'b0;
        rd("rst_clear", 5'd25, 5'd25, 32'h0, 32'h0);
        wr(5'd26, 32'h77777777);
        rd("post_rst", 5'd26, 5'd25, 32'h77777777, 32'h0);

        drive(1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd0);
        #1;
        cmp("bypass", bus.rd1, 32'hCAFEF00D);
        cmp("no_bypass", bus_nb.rd1, 32'h0);
        rst = 1'b1;
        #1;
        cmp("bypass_rst", bus.rd1, 32'h0);
        tick();
        rst = 1'b0;
        rd("x7_dropped", 5'd7, 5'd7, 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            reg_addr_t a;
            rst = ($urandom_range(0, 40) == 0);
            a = reg_addr_t'($urandom_range(0, NREGS - 1));
            drive(logic'($urandom_range(0, 1)), a, xword_t'($urandom),
                  ($urandom_range(0, 2) == 0) ? a : reg_addr_t'($urandom_range(0, NREGS - 1)),
                  ($urandom_range(0, 2) == 0) ? a : reg_addr_t'($urandom_range(0, NREGS - 1)));
            #1;
            probe("rand");
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < NREGS; i += 2) begin
            drive(1'b0, '0, '0, reg_addr_t'(i), reg_addr_t'(i + 1));
            #1;
            probe("final");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
